// File: rtl/decode_p3.sv
// decode_p3: ID-stage of a small in-order pipeline. Holds the register file,
// detects load-use hazards, produces the ID/EX pipeline register, the branch
// target and front-end control, and a run/halt controller.
// Optional debug port: define DECODE_P3_DEBUG_REGS_EN to expose dbg_regs.
module decode_p3 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned CTRL_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [15:0]       id_pc,
  input  logic              id_uses_rs,
  input  logic              id_uses_rd,
  input  logic              id_dst_sel,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              id_branch_taken,
  input  logic              id_halt,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic [15:0]       branch_target,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_ar,
  output logic [DATA_W-1:0] ex_br,
  output logic [2:0]        ex_rs,
  output logic [2:0]        ex_rd,
  output logic [2:0]        ex_dst,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        state,
  output logic [15:0]       stall_count
`ifdef DECODE_P3_DEBUG_REGS_EN
  ,
  output logic [NREG*DATA_W-1:0] dbg_regs
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t            st;
  logic [DATA_W-1:0] regs [NREG];
  logic [2:0]        rs;
  logic [2:0]        rd;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rd_val;
  logic              hazard;
  logic              accept;
  logic              unused_instr_bits;

  assign rs    = id_instr[13:11];
  assign rd    = id_instr[10:8];
  assign state = st;
  assign unused_instr_bits = ^id_instr[15:14];

  // Register file reads with same-cycle writeback bypass; out-of-range reads give 0
  always_comb begin
    rs_val = '0;
    rd_val = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rs == 3'(i)) rs_val = (wb_we && wb_addr == rs) ? wb_data : regs[i];
      if (rd == 3'(i)) rd_val = (wb_we && wb_addr == rd) ? wb_data : regs[i];
    end
  end

  // Load-use hazard detection and front-end control
  always_comb begin
    hazard = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
             ((id_uses_rs && rs == ex_dst) || (id_uses_rd && rd == ex_dst));
    accept        = (st == RUN) && !hazard;
    pc_write      = accept;
    if_id_write   = accept;
    if_id_flush   = accept && id_valid && id_branch_taken;
    branch_target = id_pc + {{8{id_instr[7]}}, id_instr[7:0]};
  end

  // Register file write port; active in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (wb_we && wb_addr == 3'(i)) regs[i] <= wb_data;
      end
    end
  end

  // ID/EX pipeline register: load on accept, otherwise insert a bubble
  always_ff @(posedge clock) begin
    if (reset || !accept) begin
      ex_valid     <= 1'b0;
      ex_ar        <= '0;
      ex_br        <= '0;
      ex_rs        <= '0;
      ex_rd        <= '0;
      ex_dst       <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_ar        <= rs_val;
      ex_br        <= rd_val;
      ex_rs        <= rs;
      ex_rd        <= rd;
      ex_dst       <= id_dst_sel ? rs : rd;
      ex_mem_read  <= id_mem_read;
      ex_reg_write <= id_reg_write;
      ex_ctrl      <= id_ctrl;
    end
  end

  // Run/halt controller and saturating load-use stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= IDLE;
      stall_count <= '0;
    end else begin
      if (st == RUN && hazard && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      case (st)
        IDLE:    if (exec) st <= RUN;
        RUN:     if (accept && id_valid && id_halt) st <= HALT;
        HALT:    if (exec) st <= RUN;
        default: st <= IDLE;
      endcase
    end
  end

`ifdef DECODE_P3_DEBUG_REGS_EN
  // Flattened register file view
  always_comb begin
    dbg_regs = '0;
    for (int i = 0; i < int'(NREG); i++) dbg_regs[i*DATA_W +: DATA_W] = regs[i];
  end
`endif

endmodule

// File: tb/tb_decode_p3.sv
// tb_decode_p3: directed plus randomized checks of decode_p3 against a
// behavioural model of the decode stage kept in this bench.
module tb_decode_p3;

  localparam int NR = 8;

  logic        clock, reset, exec;
  logic        id_valid;
  logic [15:0] id_instr, id_pc;
  logic        id_uses_rs, id_uses_rd, id_dst_sel;
  logic        id_mem_read, id_reg_write, id_branch_taken, id_halt;
  logic [11:0] id_ctrl;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        pc_write, if_id_write, if_id_flush;
  logic [15:0] branch_target;
  logic        ex_valid;
  logic [15:0] ex_ar, ex_br;
  logic [2:0]  ex_rs, ex_rd, ex_dst;
  logic        ex_mem_read, ex_reg_write;
  logic [11:0] ex_ctrl;
  logic [1:0]  state;
  logic [15:0] stall_count;

  decode_p3 dut (
    .clock(clock), .reset(reset), .exec(exec), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_uses_rs(id_uses_rs),
    .id_uses_rd(id_uses_rd), .id_dst_sel(id_dst_sel), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .id_branch_taken(id_branch_taken),
    .id_halt(id_halt), .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .branch_target(branch_target),
    .ex_valid(ex_valid), .ex_ar(ex_ar), .ex_br(ex_br), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl), .state(state),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: machine state as 0=idle 1=run 2=halt, register file, EX latch
  int          m_state = 0;
  logic [15:0] m_regs [NR];
  logic        m_valid = 0, m_mr = 0, m_rw = 0, m_known = 1;
  logic [15:0] m_ar = 0, m_br = 0, m_sc = 0;
  logic [2:0]  m_rs = 0, m_rd = 0, m_dst = 0;
  logic [11:0] m_ctrl = 0;

  // Comb outputs sampled in the last cycle
  logic        s_pc, s_fl;
  logic [15:0] s_bt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mread(input logic [2:0] a);
    if (int'(a) >= NR) return 16'h0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // One clock: check comb outputs at negedge, advance model, check EX after the edge
  task automatic cyc();
    logic [2:0]  rs, rd;
    logic        hz, acc;
    logic [15:0] ar, br, bt;
    rs = id_instr[13:11];
    rd = id_instr[10:8];
    @(negedge clock);
    hz  = id_valid && m_valid && m_mr && m_rw &&
          ((id_uses_rs && rs == m_dst) || (id_uses_rd && rd == m_dst));
    acc = (m_state == 1) && !hz;
    bt  = 16'(int'(id_pc) + int'($signed(id_instr[7:0])));
    s_pc = pc_write; s_fl = if_id_flush; s_bt = branch_target;
    check("pc_write", 64'(pc_write), 64'(acc));
    check("if_id_write", 64'(if_id_write), 64'(acc));
    check("if_id_flush", 64'(if_id_flush), 64'(acc && id_valid && id_branch_taken));
    check("branch_target", 64'(branch_target), 64'(bt));
    if (reset) begin
      m_state = 0; m_valid = 0; m_mr = 0; m_rw = 0; m_known = 1;
      m_ar = 0; m_br = 0; m_rs = 0; m_rd = 0; m_dst = 0; m_ctrl = 0; m_sc = 0;
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
    end else begin
      ar = mread(rs);
      br = mread(rd);
      if (acc) begin
        m_valid = id_valid; m_mr = id_mem_read; m_rw = id_reg_write; m_known = 1;
        m_ar = ar; m_br = br; m_rs = rs; m_rd = rd; m_ctrl = id_ctrl;
        m_dst = id_dst_sel ? rs : rd;
      end else begin
        m_valid = 0; m_mr = 0; m_rw = 0; m_known = 0;
      end
      if (m_state == 1 && hz && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (m_state == 0 && exec) m_state = 1;
      else if (m_state == 1 && acc && id_valid && id_halt) m_state = 2;
      else if (m_state == 2 && exec) m_state = 1;
      if (wb_we && int'(wb_addr) < NR) m_regs[wb_addr] = wb_data;
    end
    @(posedge clock);
    #1;
    check("state", 64'(state), 64'(m_state));
    check("stall_count", 64'(stall_count), 64'(m_sc));
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("ex_mem_read", 64'(ex_mem_read), 64'(m_mr));
    check("ex_reg_write", 64'(ex_reg_write), 64'(m_rw));
    if (m_known) begin
      check("ex_ar", 64'(ex_ar), 64'(m_ar));
      check("ex_br", 64'(ex_br), 64'(m_br));
      check("ex_rs", 64'(ex_rs), 64'(m_rs));
      check("ex_rd", 64'(ex_rd), 64'(m_rd));
      check("ex_dst", 64'(ex_dst), 64'(m_dst));
      check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    end
  endtask

  task automatic quiet();
    exec = 0; id_valid = 0; id_instr = 0; id_pc = 0; id_uses_rs = 0; id_uses_rd = 0;
    id_dst_sel = 0; id_mem_read = 0; id_reg_write = 0; id_branch_taken = 0;
    id_halt = 0; id_ctrl = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rd, input logic [7:0] imm);
    return {2'b00, rs, rd, imm};
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
    quiet();
    reset = 1;
    @(posedge clock); #1;
    cyc();
    check("reset_state", 64'(state), 64'h0);
    check("reset_stall", 64'(stall_count), 64'h0);
    check("reset_ex_valid", 64'(ex_valid), 64'h0);

    // Start
    reset = 0; exec = 1;
    cyc();
    check("start_state", 64'(state), 64'h1);
    exec = 0;
    cyc();
    check("start_pc_write", 64'(s_pc), 64'h1);

    // Writeback bypass into operand A
    id_valid = 1; id_instr = mk(3'd3, 3'd0, 8'h00); id_uses_rs = 1;
    wb_we = 1; wb_addr = 3'd3; wb_data = 16'h1234;
    cyc();
    check("bypass_ex_ar", 64'(ex_ar), 64'h1234);
    quiet();

    // Load-use stall on rd
    id_valid = 1; id_instr = mk(3'd5, 3'd2, 8'h00); id_mem_read = 1; id_reg_write = 1;
    cyc();
    quiet();
    id_valid = 1; id_instr = mk(3'd6, 3'd2, 8'h00); id_uses_rd = 1; id_ctrl = 12'hABC;
    cyc();
    check("stall_pc_write", 64'(s_pc), 64'h0);
    check("stall_bubble", 64'(ex_valid), 64'h0);
    check("stall_count_1", 64'(stall_count), 64'h1);
    cyc();
    check("issue_pc_write", 64'(s_pc), 64'h1);
    check("issue_ex_valid", 64'(ex_valid), 64'h1);
    check("issue_ex_ctrl", 64'(ex_ctrl), 64'hABC);

    // Taken branch with negative offset
    quiet();
    id_valid = 1; id_pc = 16'h0010; id_instr = mk(3'd1, 3'd1, 8'hFE); id_branch_taken = 1;
    cyc();
    check("branch_target", 64'(s_bt), 64'h000E);
    check("branch_flush", 64'(s_fl), 64'h1);
    quiet();
    cyc();
    check("branch_flush_once", 64'(s_fl), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom % 100) == 0;
      exec = ($urandom % 4) == 0;
      id_valid = ($urandom % 5) != 0;
      id_instr = 16'($urandom);
      id_pc = 16'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rd = 1'($urandom);
      id_dst_sel = 1'($urandom); id_mem_read = 1'($urandom);
      id_reg_write = ($urandom % 4) != 0; id_branch_taken = ($urandom % 4) == 0;
      id_halt = ($urandom % 30) == 0; id_ctrl = 12'($urandom);
      wb_we = 1'($urandom); wb_addr = 3'($urandom); wb_data = 16'($urandom);
      cyc();
    end

    // Halt, resume, write during halt, reset during halt
    quiet(); reset = 0; exec = 1;
    cyc();
    exec = 0;
    cyc();
    check("pre_halt_run", 64'(state), 64'h1);
    id_valid = 1; id_halt = 1; id_instr = mk(3'd0, 3'd0, 8'h00);
    cyc();
    check("halt_state", 64'(state), 64'h2);
    check("halt_in_ex", 64'(ex_valid), 64'h1);
    quiet(); wb_we = 1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    cyc();
    check("halt_pc_write", 64'(s_pc), 64'h0);
    quiet(); exec = 1;
    cyc();
    check("resume_state", 64'(state), 64'h1);
    quiet(); id_valid = 1; id_instr = mk(3'd5, 3'd0, 8'h00);
    cyc();
    check("halt_write_kept", 64'(ex_ar), 64'hBEEF);
    id_halt = 1;
    cyc();
    check("halt_again", 64'(state), 64'h2);
    quiet(); reset = 1;
    cyc();
    check("halt_reset_state", 64'(state), 64'h0);
    reset = 0; exec = 1;
    cyc();
    quiet(); id_valid = 1; id_instr = mk(3'd5, 3'd0, 8'h00);
    cyc();
    check("reset_clears_regs", 64'(ex_ar), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_p3.md
DECODE_P3 -- requirements
Module: decode_p3

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/operand width (16..32).
REQ-002 SHALL have parameter NREG, default 8, meaning number of general registers (2..8).
REQ-003 SHALL have parameter CTRL_W, default 12, meaning width of the opaque control bundle passed to EX.
REQ-004 SHALL have the following ports, in this order:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- exec  in  1  start/resume request.
- id_valid  in  1  the IF/ID slot holds a real instruction.
- id_instr  in  16  fields: rs=[13:11], rd=[10:8], imm8=[7:0].
- id_pc  in  16  PC of the ID instruction.
- id_uses_rs / id_uses_rd  in  1 each  source-operand usage flags.
- id_dst_sel  in  1  destination select: 0=rd, 1=rs.
- id_mem_read / id_reg_write / id_branch_taken / id_halt  in  1 each  decoded flags.
- id_ctrl  in  CTRL_W  passthrough control bundle.
- wb_we  in  1  writeback enable.
- wb_addr  in  3  writeback register address.
- wb_data  in  DATA_W  writeback data.
- pc_write / if_id_write / if_id_flush  out  1 each  front-end control.
- branch_target  out  16  branch target address.
- ex_valid  out  1  ID/EX valid.
- ex_ar / ex_br  out  DATA_W each  ID/EX operands.
- ex_rs / ex_rd / ex_dst  out  3 each  ID/EX register fields.
- ex_mem_read / ex_reg_write  out  1 each  ID/EX flags.
- ex_ctrl  out  CTRL_W  ID/EX control bundle.
- state  out  2  00=IDLE, 01=RUN, 10=HALT.
- stall_count  out  16  load-use stall cycle counter.

Function
REQ-005 SHALL hold an NREG x DATA_W register file written on the rising edge when wb_we=1 and wb_addr<NREG; writes with wb_addr>=NREG SHALL be ignored.
REQ-006 SHALL read the register file combinationally at rs and rd; when wb_we=1 and wb_addr equals the read address, the read SHALL return wb_data (same-cycle bypass); an address >=NREG SHALL read 0.
REQ-007 SHALL compute branch_target = id_pc + sign-extended imm8, modulo 2^16, combinationally.
REQ-008 SHALL assert hazard when id_valid, ex_valid, ex_mem_read and ex_reg_write are all 1, and either (id_uses_rs and rs==ex_dst) or (id_uses_rd and rd==ex_dst).
REQ-009 In RUN with hazard=1: pc_write=0, if_id_write=0, if_id_flush=0; ID/EX SHALL load a bubble (ex_valid=0, ex_mem_read=0, ex_reg_write=0); stall_count SHALL increment, saturating at 0xFFFF.
REQ-010 In RUN with hazard=0: pc_write=1, if_id_write=1; ID/EX SHALL load the operands, fields, flags, id_ctrl and ex_valid=id_valid on the next edge; latency ID->EX SHALL be one cycle.
REQ-011 In RUN with hazard=0, id_valid=1 and id_branch_taken=1: if_id_flush SHALL be 1 in that same cycle only.
REQ-012 ex_dst SHALL capture rd when id_dst_sel=0 and rs when id_dst_sel=1.
REQ-013 FSM transitions: IDLE->RUN when exec=1; RUN->HALT on an accepted (non-stalled) id_valid with id_halt=1; HALT->RUN when exec=1; all other conditions SHALL hold the current state.
REQ-014 The halt instruction itself SHALL enter ID/EX; in IDLE and HALT, pc_write=if_id_write=if_id_flush=0 and ID/EX SHALL load bubbles.
REQ-015 Priority: a load-use stall SHALL suppress branch flush and halt acceptance in that cycle; register file writes SHALL proceed in every state.

Reset
REQ-016 On reset=1 at an edge: state=IDLE, ID/EX cleared (all outputs 0, ex_valid=0), stall_count=0, all registers=0; reset SHALL override every concurrent event, including a mid-stall or mid-halt condition.

Configuration
REQ-017 With macro DECODE_P3_DEBUG_REGS_EN defined, SHALL add output dbg_regs [NREG*DATA_W-1:0], with register i at bits [i*DATA_W +: DATA_W]; without the macro, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-018 Reset, exec=1 for one cycle -> state 00 to 01; pc_write=1 on the next cycle.
REQ-019 wb_we=1, wb_addr=3, wb_data=0x1234 while ID rs=3 -> ex_ar=0x1234 on the next cycle (bypass).
REQ-020 Load with ex_dst=2 in EX, ID uses rd=2 -> one cycle with pc_write=0, ex_valid=0 next, stall_count=1; instruction issued the cycle after.
REQ-021 id_pc=0x0010, imm8=0xFE, taken -> branch_target=0x000E, if_id_flush=1 for exactly one cycle.
REQ-022 Accepted halt -> state=10, pc_write=0; exec=1 -> state=01; reset asserted during HALT -> state=00 and all registers 0.
